// File: rtl/state_dump_unit.sv
// state_dump_unit
//   Stalls the core and streams the contents of up to NUM_SRC storage arrays
//   (0 instr mem, 1 data mem, 2 register bank), one word at a time, over a
//   valid/ready interface. Each word carries its source tag and word index.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   start         : dump request, only looked at while idle
//   src_mask      : bit i selects source i, captured when start is accepted
//   cpu_stall     : freezes PC/register/memory writes while high
//   rd_sel/rd_addr: source and word index presented to the shared read mux
//   rd_data       : combinational read data, slice i belongs to source i
//   out_*         : dumped word stream (valid/ready, data, src, idx, last)
//   busy          : high whenever not idle
//   done          : one-cycle pulse when the dump has finished
module state_dump_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_SRC-1:0]        src_mask,
  output logic                      cpu_stall,
  output logic [SRC_W-1:0]          rd_sel,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [NUM_SRC*DATA_W-1:0] rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic [ADDR_W-1:0]         out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STALL,
    S_READ,
    S_SEND,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_SRC-1:0]  r_mask;
  logic [SRC_W-1:0]    r_sel;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_valid;
  logic                r_last;
  logic [DATA_W-1:0]   r_data;
  logic [SRC_W-1:0]    r_src;
  logic [ADDR_W-1:0]   r_idx;

  logic [DATA_W-1:0]   w_rd_word;
  logic                w_hs;
  logic                w_addr_end;
  logic                w_more;

  // True when any enabled source lies above the current one.
  function automatic logic higher_set(input logic [NUM_SRC-1:0] mask,
                                      input logic [SRC_W-1:0]   sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mask[i] && (i > int'(sel))) hit = 1'b1;
    end
    return hit;
  endfunction

  // Lowest enabled source at or above index lo (scan downward so the lowest wins).
  function automatic logic [SRC_W-1:0] lowest_from(input logic [NUM_SRC-1:0] mask,
                                                   input int                 lo);
    logic [SRC_W-1:0] res;
    res = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) res = SRC_W'(i);
    end
    return res;
  endfunction

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_sel == SRC_W'(i)) w_rd_word = rd_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_hs       = r_valid && out_ready;
  assign w_addr_end = (r_addr == LAST_ADDR);
  assign w_more     = higher_set(r_mask, r_sel);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_STALL;
      // One quiet cycle lets in-flight core writes land before reading.
      S_STALL: w_state_nxt = (r_mask == '0) ? S_FIN : S_READ;
      S_READ:  w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_hs) w_state_nxt = (!w_addr_end || w_more) ? S_READ : S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask  <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_mask <= src_mask;
        S_STALL: begin
          r_sel  <= lowest_from(r_mask, 0);
          r_addr <= '0;
        end
        S_READ: begin
          r_data  <= w_rd_word;
          r_src   <= r_sel;
          r_idx   <= r_addr;
          r_valid <= 1'b1;
          r_last  <= w_addr_end && !w_more;
        end
        S_SEND: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (!w_addr_end) begin
              r_addr <= r_addr + ADDR_W'(1);
            end else if (w_more) begin
              r_sel  <= lowest_from(r_mask, int'(r_sel) + 1);
              r_addr <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_stall = (r_state == S_STALL) || (r_state == S_READ) || (r_state == S_SEND);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign rd_sel    = r_sel;
  assign rd_addr   = r_addr;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_idx   = r_idx;
  assign out_last  = r_last;

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit: one instance with DEPTH=32 and one with
// DEPTH=4; sel4 chooses which instance the stimulus and checks address.
module tb_state_dump_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NSRC   = 3;
  localparam int SRC_W  = 2;

  logic clk = 1'b0;
  logic reset, start, sel4, out_ready;
  logic [NSRC-1:0] src_mask;

  logic start32, start4;
  logic stall32, stall4, valid32, valid4, last32, last4;
  logic busy32, busy4, done32, done4;
  logic [SRC_W-1:0]  rsel32, rsel4, osrc32, osrc4;
  logic [ADDR_W-1:0] raddr32, raddr4, oidx32, oidx4;
  logic [DATA_W-1:0] odata32, odata4;
  logic [NSRC*DATA_W-1:0] rdata32, rdata4;

  logic obs_stall, obs_valid, obs_last, obs_busy, obs_done;
  logic [SRC_W-1:0]  obs_src, obs_rsel;
  logic [ADDR_W-1:0] obs_idx, obs_raddr;
  logic [DATA_W-1:0] obs_data;

  always #5 clk = ~clk;

  // Array contents: instr mem 0x1000_00xx, data mem 0x2000_00xx, register bank i*4.
  function automatic logic [31:0] mem_word(input int s, input logic [4:0] idx);
    case (s)
      0:       return 32'h1000_0000 | {27'b0, idx};
      1:       return 32'h2000_0000 | {27'b0, idx};
      default: return {25'b0, idx, 2'b00};
    endcase
  endfunction

  always_comb begin
    rdata32 = '0;
    rdata4  = '0;
    for (int s = 0; s < NSRC; s++) begin
      rdata32[s*DATA_W +: DATA_W] = mem_word(s, raddr32);
      rdata4[s*DATA_W +: DATA_W]  = mem_word(s, raddr4);
    end
  end

  assign start32 = start & ~sel4;
  assign start4  = start & sel4;

  state_dump_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32), .NUM_SRC(NSRC), .SRC_W(SRC_W)) dut (
    .clk(clk), .reset(reset), .start(start32), .src_mask(src_mask),
    .cpu_stall(stall32), .rd_sel(rsel32), .rd_addr(raddr32), .rd_data(rdata32),
    .out_valid(valid32), .out_ready(out_ready), .out_data(odata32), .out_src(osrc32),
    .out_idx(oidx32), .out_last(last32), .busy(busy32), .done(done32)
  );

  state_dump_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(4), .NUM_SRC(NSRC), .SRC_W(SRC_W)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .src_mask(src_mask),
    .cpu_stall(stall4), .rd_sel(rsel4), .rd_addr(raddr4), .rd_data(rdata4),
    .out_valid(valid4), .out_ready(out_ready), .out_data(odata4), .out_src(osrc4),
    .out_idx(oidx4), .out_last(last4), .busy(busy4), .done(done4)
  );

  assign obs_stall = sel4 ? stall4 : stall32;
  assign obs_valid = sel4 ? valid4 : valid32;
  assign obs_last  = sel4 ? last4  : last32;
  assign obs_busy  = sel4 ? busy4  : busy32;
  assign obs_done  = sel4 ? done4  : done32;
  assign obs_src   = sel4 ? osrc4  : osrc32;
  assign obs_rsel  = sel4 ? rsel4  : rsel32;
  assign obs_idx   = sel4 ? oidx4  : oidx32;
  assign obs_raddr = sel4 ? raddr4 : raddr32;
  assign obs_data  = sel4 ? odata4 : odata32;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [SRC_W-1:0]  cap_src  [0:127];
  logic [ADDR_W-1:0] cap_idx  [0:127];
  logic [DATA_W-1:0] cap_data [0:127];
  logic              cap_last [0:127];
  int n_words, n_done, done_cyc, n_stall, n_unstable, n_valid_seen;

  // Launches a dump and follows it until done. mode 1 drives out_ready 1-0-0-1.
  // inject_at >= 0 pulses start with inj_mask once that many words were taken.
  // fin_start raises start in the FIN cycle and the IDLE cycle after it.
  task automatic run_dump(input logic [2:0] mask, input int mode, input int inject_at,
                          input logic [2:0] inj_mask, input bit fin_start);
    logic pv, phs, pl;
    logic [31:0] pd;
    logic [1:0]  ps;
    logic [4:0]  pi;
    bit injected, fin;
    n_words = 0; n_done = 0; done_cyc = -1; n_stall = 0; n_unstable = 0; n_valid_seen = 0;
    pv = 0; phs = 0; pl = 0; pd = 0; ps = 0; pi = 0; injected = 0; fin = 0;
    out_ready = 1'b1;
    src_mask  = mask;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    src_mask = ~mask;
    check("start_accepted_busy", obs_busy, 1);
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      start = 1'b0;
      if (mode == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else           out_ready = 1'b1;
      if (pv && !phs) begin
        if (!obs_valid || obs_data !== pd || obs_src !== ps || obs_idx !== pi || obs_last !== pl)
          n_unstable++;
      end
      if (obs_stall) n_stall++;
      if (obs_valid) n_valid_seen++;
      if (obs_valid && out_ready && n_words < 128) begin
        cap_src[n_words]  = obs_src;
        cap_idx[n_words]  = obs_idx;
        cap_data[n_words] = obs_data;
        cap_last[n_words] = obs_last;
        n_words++;
      end
      if (inject_at >= 0 && !injected && n_words == inject_at) begin
        start    = 1'b1;
        src_mask = inj_mask;
        injected = 1;
      end
      if (obs_done) begin
        n_done++;
        done_cyc = cyc;
        fin = 1;
        if (fin_start) begin
          start    = 1'b1;
          src_mask = mask;
        end
        check("fin_stall_low", obs_stall, 0);
      end
      pv = obs_valid; phs = obs_valid && out_ready;
      pd = obs_data;  ps = obs_src; pi = obs_idx; pl = obs_last;
      tick();
    end
    check("dump_finished", fin, 1);
    check("idle_after_fin", {obs_busy, obs_stall, obs_done, obs_valid}, 4'b0000);
    if (fin_start) begin
      tick();
      start = 1'b0;
      check("start_after_fin_accepted", {obs_busy, obs_stall}, 2'b11);
      fin = 0;
      for (int i = 0; i < 200 && !fin; i++) begin
        if (obs_done) fin = 1;
        else tick();
      end
      check("second_dump_done", fin, 1);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    bit found;
    reset = 1'b1; start = 1'b0; sel4 = 1'b0; out_ready = 1'b0; src_mask = '0;

    // Reset then idle
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("rst_idle_ctrl", {stall32, valid32, last32, busy32, done32}, 5'b0);
      check("rst_idle_data", {odata32, osrc32, oidx32, rsel32, raddr32}, 46'b0);
      tick();
    end
    check("rst_idle_dut4", {stall4, valid4, last4, busy4, done4, odata4, osrc4, oidx4}, 0);

    // Register bank only, full speed
    sel4 = 1'b0;
    run_dump(3'b100, 0, -1, 3'b000, 0);
    check("bank_words", n_words, 32);
    for (int i = 0; i < 32; i++)
      check($sformatf("bank_w%0d", i), {cap_src[i], cap_idx[i], cap_data[i], cap_last[i]},
            {2'd2, 5'(i), 32'(i * 4), (i == 31)});
    check("bank_done_cycle", done_cyc, 66);
    check("bank_stall_cycles", n_stall, 65);
    check("bank_done_pulses", n_done, 1);

    // Two sources, DEPTH=4, backpressure
    sel4 = 1'b1;
    run_dump(3'b011, 1, -1, 3'b000, 0);
    check("bp_words", n_words, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("bp_w%0d", i), {cap_src[i], cap_idx[i], cap_data[i], cap_last[i]},
            {2'(i / 4), 5'(i % 4), mem_word(i / 4, 5'(i % 4)), (i == 7)});
    check("bp_stable", n_unstable, 0);

    // Same mask at full speed, with start in FIN (ignored) and first IDLE (accepted)
    run_dump(3'b011, 0, -1, 3'b000, 1);
    check("two_src_done_cycle", done_cyc, 18);
    check("two_src_stall_cycles", n_stall, 17);
    check("two_src_words", n_words, 8);

    // Empty mask
    sel4 = 1'b0;
    run_dump(3'b000, 0, -1, 3'b000, 0);
    check("empty_stall_cycles", n_stall, 1);
    check("empty_done_cycle", done_cyc, 2);
    check("empty_valid_seen", n_valid_seen, 0);

    // Reset during SEND of word 5
    src_mask = 3'b100; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (valid32 && oidx32 == 5'd5) begin
        found = 1;
        out_ready = 1'b0;
      end else begin
        tick();
      end
    end
    check("midrst_reached_w5", found, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_outputs", {valid32, stall32, busy32, done32}, 4'b0000);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (done32 || busy32) bad++;
      tick();
    end
    check("midrst_no_done", bad, 0);
    run_dump(3'b100, 0, -1, 3'b000, 0);
    check("midrst_redump_first", {cap_idx[0], cap_data[0]}, {5'd0, 32'h0});
    check("midrst_redump_words", n_words, 32);

    // start while busy with another mask
    run_dump(3'b001, 0, 10, 3'b110, 0);
    check("busy_start_words", n_words, 32);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (cap_src[i] !== 2'd0 || cap_idx[i] !== 5'(i) || cap_data[i] !== mem_word(0, 5'(i))) bad++;
    check("busy_start_content", bad, 0);
    check("busy_start_done_cycle", done_cyc, 66);
    tick(); tick();
    check("busy_start_stays_idle", {busy32, stall32}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
- Parametrised hardware successor to the processor bench's end-of-run memory/register dump.
- On request, stalls the RISC-V core and walks up to NUM_SRC storage arrays (instruction memory, data memory, register bank), word by word.
- Streams each word out over a valid/ready interface tagged with source and index, so dumps work on silicon and in simulation.
- Sits beside procesador; shares read ports with the arrays through a read-select mux.

Parameters:
- DATA_W, 32, width of each dumped word.
- ADDR_W, 5, width of the read index.
- DEPTH, 32, words dumped per source (1..2**ADDR_W).
- NUM_SRC, 3, number of sources (0 instr mem, 1 data mem, 2 register bank).
- SRC_W, 2, width of the source tag (must be >= clog2(NUM_SRC)).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  dump request; sampled only in IDLE.
- src_mask  in  NUM_SRC  bit i=1 includes source i; latched at start.
- cpu_stall  out  1  freezes PC/register/memory writes while high.
- rd_sel  out  SRC_W  source currently addressed.
- rd_addr  out  ADDR_W  word index currently addressed.
- rd_data  in  NUM_SRC*DATA_W  combinational read data; slice i belongs to source i.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  dumped word.
- out_src  out  SRC_W  source tag of out_data.
- out_idx  out  ADDR_W  index of out_data.
- out_last  out  1  final word of the whole dump.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at dump completion.

Behaviour:
- Reset: state IDLE; cpu_stall, out_valid, out_last, busy and done are 0; out_data, out_src, out_idx, rd_sel and rd_addr are 0.
- Reset is synchronous and takes priority in any state. A mid-dump reset drops out_valid and releases cpu_stall on that edge, with no done pulse.

State machine (IDLE, STALL, READ, SEND, FIN):
- IDLE -> STALL on start=1.
  - Latch src_mask.
  - Assert cpu_stall and busy.
- STALL: one cycle so in-flight writes complete.
  - If the latched mask is 0, go to FIN.
  - Otherwise set rd_sel to the lowest set bit, rd_addr=0, and go to READ.
- READ: at the edge, capture the rd_data slice rd_sel into out_data.
  - Set out_src=rd_sel, out_idx=rd_addr, out_valid=1.
  - out_last=1 when rd_addr==DEPTH-1 and no higher mask bit is set.
  - Go to SEND.
- SEND: hold all out_* stable until out_valid && out_ready at an edge. On the handshake:
  - out_valid -> 0.
  - If rd_addr<DEPTH-1: increment rd_addr and go to READ.
  - Else if a higher mask bit is set: rd_sel = next set bit, rd_addr=0, go to READ.
  - Else go to FIN.
- FIN: done=1 and cpu_stall=0 for exactly this cycle, then IDLE; busy falls on entry to IDLE.

Timing and rules:
- Minimum 2 cycles per word (READ+SEND with out_ready held high).
- Full dump of k enabled sources takes 1 + 2*k*DEPTH + 1 cycles.
- start while busy is ignored. start in the FIN cycle is ignored. start on the first IDLE cycle after FIN is accepted.
- out_ready while out_valid=0 has no effect.
- out_valid never drops without a handshake, except on reset.
- Mask bits at index >= NUM_SRC do not exist; sources are visited in ascending order only.
- rd_addr never exceeds DEPTH-1; there is no wrap into a following source's index space.
- cpu_stall is high continuously from STALL through SEND of the last word, and in no other cycle.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, start=0 -> all outputs 0, busy=0 for 10 cycles.
- Register bank only: src_mask=3'b100, BankReg[i]=i*4, out_ready=1 -> 32 words (src=2, idx 0..31, data 0x0..0x7C); out_last only on idx 31; done pulses 66 cycles after start.
- Two sources with backpressure: mask=3'b011, DEPTH=4, out_ready toggling 1-0-0-1 -> 8 words in order (src0 idx0-3, then src1 idx0-3); out_data stable while stalled; no duplicates or drops.
- Empty mask: mask=0 -> cpu_stall high 1 cycle, then done=1 next cycle, out_valid never asserted.
- Reset mid-dump: assert reset during SEND of word 5 -> next edge: out_valid=0, cpu_stall=0, busy=0, done never pulses; a new start then dumps from idx 0.
- start while busy: pulse start at word 10 with a different mask -> ignored; the dump completes with the original mask and word count.
